wb_stage_sb: RTL and testbench
==============================

Name: wb_stage_sb

Overview:
- Parametrised write-back stage for the 5-stage pipeline; sits after MEM_WB_reg.
- Drives the register-file write port with registered, one-cycle-latency outputs.
- Owns the accumulator register.
- Queues STO writes in a store buffer that drains to data memory over a valid/ready handshake, back-pressures the MEM/WB boundary when full, and answers store-to-load forwarding lookups from MEM.

Parameters:
DATA_W, 8, width of register, accumulator and memory data
REG_AW, 5, register-file address width
MEM_AW, 8, data-memory address width
SB_DEPTH, 4, store-buffer entries, integer >= 2, not required to be a power of two
ACC_RST, 0, accumulator reset value

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
in_valid  in  1  MEM/WB holds an instruction
in_ready  out  1  stage accepts this cycle
in_reg_write  in  1  instruction writes register file
in_mem_write  in  1  instruction stores to memory
in_acc_write  in  1  instruction updates accumulator
in_dest  in  REG_AW  destination register
in_reg_data  in  DATA_W  register write data
in_acc_data  in  DATA_W  new accumulator value
in_mem_addr  in  MEM_AW  store address
in_mem_data  in  DATA_W  store data
reg_write_enable  out  1  register-file write strobe (registered)
reg_write_addr  out  REG_AW  register write address (registered)
reg_write_data  out  DATA_W  register write data (registered)
mem_write_valid  out  1  store-buffer head is valid
mem_write_ready  in  1  data memory takes head this cycle
mem_write_addr  out  MEM_AW  head address
mem_write_data  out  DATA_W  head data
accum_value  out  DATA_W  accumulator register
ld_addr  in  MEM_AW  forwarding lookup address from MEM
ld_hit  out  1  resident store matches ld_addr (combinational)
ld_data  out  DATA_W  data of youngest matching store (combinational)
sb_count  out  clog2(SB_DEPTH+1)  occupied entries
sb_empty  out  1  sb_count == 0; used for halt/fence

Behaviour:

Reset (rst = 0, asynchronous):
- reg_write_enable = 0; reg_write_addr = 0; reg_write_data = 0.
- accum_value = ACC_RST.
- Store buffer emptied: pointers 0, sb_count = 0, sb_empty = 1, mem_write_valid = 0.
- All queued entries are discarded, including any head mid-handshake. There is no completion obligation.

Acceptance:
- accept = in_valid & in_ready.
- in_ready = (sb_count != SB_DEPTH). It depends only on state and stalls every instruction, not only stores, while the buffer is full.

Register port, latency 1:
- At each edge, reg_write_enable <= accept & in_reg_write.
- On accept & in_reg_write, addr/data are loaded from in_dest/in_reg_data; otherwise they hold.
- A strobe lasts exactly one cycle per instruction.

Accumulator:
- accum_value <= in_acc_data on accept & in_acc_write; otherwise it holds.

Store buffer (circular FIFO):
- push = accept & in_mem_write writes {in_mem_addr, in_mem_data} at the write pointer.
- pop = mem_write_valid & mem_write_ready.
- Pointers wrap from SB_DEPTH-1 to 0 explicitly.
- Push and pop in the same cycle leave sb_count unchanged. Push when full cannot occur, because in_ready is 0.
- mem_write_valid = !sb_empty. Head addr/data come straight from the entry at the read pointer and stay stable while valid & !ready.
- Drain order is strict program order. A pop never depends on in_valid.
- Pop on an empty buffer is ignored; mem_write_ready is a don't-care there.

Forwarding:
- Search all resident entries, i.e. those occupying the buffer at the start of the cycle, including one being popped this cycle.
- ld_hit = any entry address == ld_addr.
- ld_data = data of the youngest matching entry, nearest the write pointer. When nothing matches, ld_data = 0.
- An entry being pushed in the same cycle is not visible until the next cycle.

Simultaneous events:
- One accepted instruction may assert reg, acc and mem writes together; all three take effect independently.
- An instruction with none set is accepted and retired with no side effects.

Test Plan:
- Reset with rst = 0 mid-drain (3 entries queued, mem_write_ready = 0) -> immediately mem_write_valid = 0, sb_count = 0, accum_value = ACC_RST, reg_write_enable = 0; after release, in_ready = 1.
- Accept reg write dest = 5, data = 0x3C at cycle N -> reg_write_enable = 1 with addr = 5, data = 0x3C in cycle N+1 only; in cycle N+2 enable = 0 and addr/data hold.
- With SB_DEPTH = 4 and mem_write_ready = 0, push stores to addr 0x10..0x13 -> sb_count = 4, in_ready = 0. A fifth in_valid (register write 0x77) is not accepted and reg_write_enable stays 0. Raise ready for one cycle -> head 0x10 pops, in_ready = 1 the next cycle, and the fifth instruction is accepted.
- Drain with ready held high -> addresses appear in order 0x10, 0x11, 0x12, 0x13, then sb_empty = 1. Repeat 6 pushes/pops to exercise pointer wrap with order preserved.
- Queue stores {0x20: 0xAA}, {0x21: 0xBB}, {0x20: 0xCC}, then set ld_addr = 0x20 -> ld_hit = 1, ld_data = 0xCC. With ld_addr = 0x22 -> ld_hit = 0, ld_data = 0. Push 0x22 this cycle -> hit appears only in the following cycle.
- One instruction with reg, acc and mem writes (acc = 0x5A) while the head pops in the same cycle -> accum_value = 0x5A next cycle, register strobe fires, sb_count unchanged.

Source files
------------

// File: rtl/wb_stage_sb_if.sv
// rtl/wb_stage_sb_if.sv - MEM/WB input, register/memory write and forwarding signals of wb_stage_sb
interface wb_stage_sb_if #(
  parameter int DATA_W   = 8,
  parameter int REG_AW   = 5,
  parameter int MEM_AW   = 8,
  parameter int SB_DEPTH = 4
);
  localparam int CNT_W = $clog2(SB_DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic              in_reg_write;
  logic              in_mem_write;
  logic              in_acc_write;
  logic [REG_AW-1:0] in_dest;
  logic [DATA_W-1:0] in_reg_data;
  logic [DATA_W-1:0] in_acc_data;
  logic [MEM_AW-1:0] in_mem_addr;
  logic [DATA_W-1:0] in_mem_data;

  logic              reg_write_enable;
  logic [REG_AW-1:0] reg_write_addr;
  logic [DATA_W-1:0] reg_write_data;

  logic              mem_write_valid;
  logic              mem_write_ready;
  logic [MEM_AW-1:0] mem_write_addr;
  logic [DATA_W-1:0] mem_write_data;

  logic [DATA_W-1:0] accum_value;

  logic [MEM_AW-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;

  logic [CNT_W-1:0]  sb_count;
  logic              sb_empty;

  modport slave (
    input  in_valid, in_reg_write, in_mem_write, in_acc_write, in_dest,
           in_reg_data, in_acc_data, in_mem_addr, in_mem_data,
           mem_write_ready, ld_addr,
    output in_ready, reg_write_enable, reg_write_addr, reg_write_data,
           mem_write_valid, mem_write_addr, mem_write_data, accum_value,
           ld_hit, ld_data, sb_count, sb_empty
  );

  modport master (
    output in_valid, in_reg_write, in_mem_write, in_acc_write, in_dest,
           in_reg_data, in_acc_data, in_mem_addr, in_mem_data,
           mem_write_ready, ld_addr,
    input  in_ready, reg_write_enable, reg_write_addr, reg_write_data,
           mem_write_valid, mem_write_addr, mem_write_data, accum_value,
           ld_hit, ld_data, sb_count, sb_empty
  );
endinterface

// File: rtl/wb_stage_sb.sv
// rtl/wb_stage_sb.sv - write-back stage with registered reg-file port, accumulator and store buffer
module wb_stage_sb #(
  parameter int                DATA_W   = 8,
  parameter int                REG_AW   = 5,
  parameter int                MEM_AW   = 8,
  parameter int                SB_DEPTH = 4,
  parameter logic [DATA_W-1:0] ACC_RST  = '0
) (
  input logic          clk,
  input logic          rst,
  wb_stage_sb_if.slave bus
);
  localparam int               PTR_W    = $clog2(SB_DEPTH);
  localparam int               CNT_W    = $clog2(SB_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(SB_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SB_DEPTH);

  logic [MEM_AW-1:0] r_sb_addr [SB_DEPTH];
  logic [DATA_W-1:0] r_sb_data [SB_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              r_reg_we;
  logic [REG_AW-1:0] r_reg_addr;
  logic [DATA_W-1:0] r_reg_data;
  logic [DATA_W-1:0] r_acc;

  logic              w_ready;
  logic              w_accept;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_ld_hit;
  logic [DATA_W-1:0] w_ld_data;

  // Explicit wrap so non-power-of-two depths index only real entries.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // Slot holding the off-th oldest entry, counted from the read pointer.
  function automatic logic [PTR_W-1:0] slot_at(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= SB_DEPTH) s = s - SB_DEPTH;
    return s[PTR_W-1:0];
  endfunction

  // Full buffer stalls every instruction; ready depends on state only.
  assign w_ready  = (r_count != FULL_CNT);
  assign w_accept = bus.in_valid & w_ready;
  assign w_empty  = (r_count == '0);
  assign w_push   = w_accept & bus.in_mem_write;
  assign w_pop    = ~w_empty & bus.mem_write_ready;

  // Register-file strobe is one cycle per accepted write; addr/data hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_we   <= 1'b0;
      r_reg_addr <= '0;
      r_reg_data <= '0;
    end else begin
      r_reg_we <= w_accept & bus.in_reg_write;
      if (w_accept & bus.in_reg_write) begin
        r_reg_addr <= bus.in_dest;
        r_reg_data <= bus.in_reg_data;
      end
    end
  end

  // Accumulator loads only on an accepted accumulator update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= ACC_RST;
    end else if (w_accept & bus.in_acc_write) begin
      r_acc <= bus.in_acc_data;
    end
  end

  // Store-buffer pointers and occupancy; reset discards any queued stores.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_sb_addr[r_wr_ptr] <= bus.in_mem_addr;
      r_sb_data[r_wr_ptr] <= bus.in_mem_data;
    end
  end

  // Scan oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    w_ld_hit  = 1'b0;
    w_ld_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if ((i < int'(r_count)) && (r_sb_addr[slot_at(r_rd_ptr, i)] == bus.ld_addr)) begin
        w_ld_hit  = 1'b1;
        w_ld_data = r_sb_data[slot_at(r_rd_ptr, i)];
      end
    end
  end

  assign bus.in_ready         = w_ready;
  assign bus.reg_write_enable = r_reg_we;
  assign bus.reg_write_addr   = r_reg_addr;
  assign bus.reg_write_data   = r_reg_data;
  assign bus.accum_value      = r_acc;
  assign bus.mem_write_valid  = ~w_empty;
  assign bus.mem_write_addr   = r_sb_addr[r_rd_ptr];
  assign bus.mem_write_data   = r_sb_data[r_rd_ptr];
  assign bus.ld_hit           = w_ld_hit;
  assign bus.ld_data          = w_ld_data;
  assign bus.sb_count         = r_count;
  assign bus.sb_empty         = w_empty;
endmodule

// File: tb/tb_wb_stage_sb.sv
// tb/tb_wb_stage_sb.sv - randomized self-checking bench for wb_stage_sb with queue-based model
module tb_wb_stage_sb;
  localparam int DATA_W   = 8;
  localparam int REG_AW   = 5;
  localparam int MEM_AW   = 8;
  localparam int SB_DEPTH = 4;
  localparam logic [DATA_W-1:0] ACC_RST = 8'h00;

  logic clk;
  logic rst;

  wb_stage_sb_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_AW(MEM_AW), .SB_DEPTH(SB_DEPTH)) bus ();

  wb_stage_sb #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_AW(MEM_AW), .SB_DEPTH(SB_DEPTH), .ACC_RST(ACC_RST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: stores as {addr, data} in program order, oldest at index 0.
  logic [15:0]       m_sb [$];
  logic              m_reg_en;
  logic [REG_AW-1:0] m_reg_addr;
  logic [DATA_W-1:0] m_reg_data;
  logic [DATA_W-1:0] m_acc;
  logic [MEM_AW-1:0] heads [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_sb.delete();
    m_reg_en   = 1'b0;
    m_reg_addr = '0;
    m_reg_data = '0;
    m_acc      = ACC_RST;
  endtask

  task automatic check_outputs();
    logic              exp_hit;
    logic [DATA_W-1:0] exp_ld;
    exp_hit = 1'b0;
    exp_ld  = '0;
    for (int i = m_sb.size() - 1; i >= 0; i--) begin
      if (!exp_hit && m_sb[i][15:8] == bus.ld_addr) begin
        exp_hit = 1'b1;
        exp_ld  = m_sb[i][7:0];
      end
    end
    check("in_ready", bus.in_ready, m_sb.size() != SB_DEPTH);
    check("reg_en", bus.reg_write_enable, m_reg_en);
    check("reg_addr", bus.reg_write_addr, m_reg_addr);
    check("reg_data", bus.reg_write_data, m_reg_data);
    check("accum", bus.accum_value, m_acc);
    check("mem_valid", bus.mem_write_valid, m_sb.size() != 0);
    check("sb_count", bus.sb_count, m_sb.size());
    check("sb_empty", bus.sb_empty, m_sb.size() == 0);
    check("ld_hit", bus.ld_hit, exp_hit);
    check("ld_data", bus.ld_data, exp_ld);
    if (m_sb.size() != 0) begin
      check("head_addr", bus.mem_write_addr, m_sb[0][15:8]);
      check("head_data", bus.mem_write_data, m_sb[0][7:0]);
    end
  endtask

  task automatic model_update();
    bit acc_ok;
    bit pop;
    acc_ok   = bus.in_valid && (m_sb.size() != SB_DEPTH);
    pop      = (m_sb.size() != 0) && bus.mem_write_ready;
    m_reg_en = acc_ok && bus.in_reg_write;
    if (m_reg_en) begin
      m_reg_addr = bus.in_dest;
      m_reg_data = bus.in_reg_data;
    end
    if (acc_ok && bus.in_acc_write) m_acc = bus.in_acc_data;
    if (pop) void'(m_sb.pop_front());
    if (acc_ok && bus.in_mem_write) m_sb.push_back({bus.in_mem_addr, bus.in_mem_data});
  endtask

  // Inputs are set at the falling edge; check, let the rising edge happen, advance the model.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_in(input bit v, input bit rw, input bit mw, input bit aw,
                        input logic [REG_AW-1:0] dest, input logic [DATA_W-1:0] rdata,
                        input logic [DATA_W-1:0] adata, input logic [MEM_AW-1:0] maddr,
                        input logic [DATA_W-1:0] mdata);
    bus.in_valid     = v;
    bus.in_reg_write = rw;
    bus.in_mem_write = mw;
    bus.in_acc_write = aw;
    bus.in_dest      = dest;
    bus.in_reg_data  = rdata;
    bus.in_acc_data  = adata;
    bus.in_mem_addr  = maddr;
    bus.in_mem_data  = mdata;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  task automatic store(input logic [MEM_AW-1:0] a, input logic [DATA_W-1:0] d);
    set_in(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, '0, a, d);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    bus.mem_write_ready = 1'b0;
    bus.ld_addr         = 8'hFF;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_reg_en", bus.reg_write_enable, 1'b0);
    check("rst_accum", bus.accum_value, ACC_RST);
    check("rst_empty", bus.sb_empty, 1'b1);
    rst = 1'b1;
    step();

    // Register strobe: exactly one cycle, addr/data hold afterwards.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 8'h3C, '0, '0, '0);
    step();
    idle();
    #1;
    check("rw_en_n1", bus.reg_write_enable, 1'b1);
    check("rw_addr_n1", bus.reg_write_addr, 5);
    check("rw_data_n1", bus.reg_write_data, 8'h3C);
    step();
    #1;
    check("rw_en_n2", bus.reg_write_enable, 1'b0);
    check("rw_addr_n2", bus.reg_write_addr, 5);
    check("rw_data_n2", bus.reg_write_data, 8'h3C);

    // Fill to full; a register write stalls until one pop frees a slot.
    for (int i = 0; i < 4; i++) begin
      store(8'(8'h10 + i), 8'(8'hA0 + i));
      step();
    end
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 8'h77, '0, '0, '0);
    #1;
    check("full_count", bus.sb_count, 4);
    check("full_ready", bus.in_ready, 1'b0);
    step();
    check("stall_reg_en", bus.reg_write_enable, 1'b0);
    bus.mem_write_ready = 1'b1;
    step();
    bus.mem_write_ready = 1'b0;
    #1;
    check("after_pop_ready", bus.in_ready, 1'b1);
    step();
    idle();
    #1;
    check("fifth_reg_en", bus.reg_write_enable, 1'b1);
    check("fifth_reg_data", bus.reg_write_data, 8'h77);

    // Drain in program order.
    bus.mem_write_ready = 1'b1;
    heads.delete();
    for (int i = 0; i < 10 && bus.mem_write_valid; i++) begin
      heads.push_back(bus.mem_write_addr);
      step();
    end
    check("drain_len", heads.size(), 3);
    for (int i = 0; i < heads.size(); i++) check("drain_order", heads[i], 8'(8'h11 + i));
    check("drain_empty", bus.sb_empty, 1'b1);

    // Push and pop concurrently to walk the pointers around the ring.
    for (int i = 0; i < 6; i++) begin
      store(8'(8'h40 + i), 8'(8'h50 + i));
      step();
    end
    idle();
    step();

    // Forwarding: youngest match wins, misses read zero, same-cycle push is invisible.
    bus.mem_write_ready = 1'b0;
    store(8'h20, 8'hAA); step();
    store(8'h21, 8'hBB); step();
    store(8'h20, 8'hCC); step();
    idle();
    bus.ld_addr = 8'h20;
    #1;
    check("fwd_hit", bus.ld_hit, 1'b1);
    check("fwd_data", bus.ld_data, 8'hCC);
    bus.ld_addr = 8'h22;
    #1;
    check("fwd_miss_hit", bus.ld_hit, 1'b0);
    check("fwd_miss_data", bus.ld_data, 8'h00);
    store(8'h22, 8'hDD);
    #1;
    check("fwd_same_cycle", bus.ld_hit, 1'b0);
    step();
    idle();
    #1;
    check("fwd_next_hit", bus.ld_hit, 1'b1);
    check("fwd_next_data", bus.ld_data, 8'hDD);

    // Free one slot, then reg+acc+mem together while the head pops.
    bus.mem_write_ready = 1'b1;
    step();
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 8'h19, 8'h5A, 8'h30, 8'h31);
    step();
    idle();
    bus.mem_write_ready = 1'b0;
    #1;
    check("multi_acc", bus.accum_value, 8'h5A);
    check("multi_reg_en", bus.reg_write_enable, 1'b1);
    check("multi_count", bus.sb_count, 3);

    // Asynchronous reset mid-drain.
    rst = 1'b0;
    #1;
    model_reset();
    check("mid_rst_valid", bus.mem_write_valid, 1'b0);
    check("mid_rst_count", bus.sb_count, 0);
    check("mid_rst_accum", bus.accum_value, ACC_RST);
    check("mid_rst_reg_en", bus.reg_write_enable, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_ready", bus.in_ready, 1'b1);
    step();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
             5'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom_range(0, 7)), 8'($urandom));
      bus.mem_write_ready = ($urandom_range(0, 2) == 0);
      bus.ld_addr         = 8'($urandom_range(0, 8));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
